// File: rtl/multicycle_control.sv
// Multi-cycle MIPS controller: Moore FSM sequencing fetch/decode/execute/memory/write-back,
// with ready-handshaked memory states, a wait watchdog and a sticky error state.
module multicycle_control #(
  parameter int unsigned WAIT_W   = 4,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_source,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       extop,
  output logic [2:0] alu_ctr,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       instr_done,
  output logic       error,
  output logic [1:0] err_code,
  output logic [3:0] state
);

  localparam logic [3:0] S_RST       = 4'd0;
  localparam logic [3:0] S_FETCH     = 4'd1;
  localparam logic [3:0] S_DECODE    = 4'd2;
  localparam logic [3:0] S_EXEC      = 4'd3;
  localparam logic [3:0] S_R_WB      = 4'd4;
  localparam logic [3:0] S_MEM_ADDR  = 4'd5;
  localparam logic [3:0] S_MEM_READ  = 4'd6;
  localparam logic [3:0] S_MEM_WB    = 4'd7;
  localparam logic [3:0] S_MEM_WRITE = 4'd8;
  localparam logic [3:0] S_IMM_EXEC  = 4'd9;
  localparam logic [3:0] S_IMM_WB    = 4'd10;
  localparam logic [3:0] S_BRANCH    = 4'd11;
  localparam logic [3:0] S_JUMP      = 4'd12;
  localparam logic [3:0] S_ERROR     = 4'd13;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [1:0] E_NONE  = 2'b00;
  localparam logic [1:0] E_OP    = 2'b01;
  localparam logic [1:0] E_FUNCT = 2'b10;
  localparam logic [1:0] E_TMO   = 2'b11;

  logic [3:0]        state_q, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic [1:0]        err_q, err_nxt;
  logic              waiting, timeout, funct_ok;
  logic [2:0]        r_alu;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_RST;
      wait_cnt <= '0;
      err_q    <= E_NONE;
    end else begin
      state_q  <= state_nxt;
      wait_cnt <= wait_nxt;
      err_q    <= err_nxt;
    end
  end

  always_comb begin
    funct_ok = 1'b1;
    r_alu    = 3'b010;
    case (funct)
      6'b100000: r_alu = 3'b010;
      6'b100010: r_alu = 3'b110;
      6'b100100: r_alu = 3'b000;
      6'b100101: r_alu = 3'b001;
      6'b101010: r_alu = 3'b111;
      default:   funct_ok = 1'b0;
    endcase
  end

  assign waiting = (state_q == S_FETCH) || (state_q == S_MEM_READ) || (state_q == S_MEM_WRITE);
  assign timeout = waiting && !mem_ready && (wait_cnt == WAIT_W'(MAX_WAIT - 1));

  always_comb begin
    state_nxt = state_q;
    err_nxt   = err_q;
    case (state_q)
      S_RST:    state_nxt = S_FETCH;
      S_DECODE: begin
        case (op)
          OP_R:           if (funct_ok) state_nxt = S_EXEC;
                          else begin state_nxt = S_ERROR; err_nxt = E_FUNCT; end
          OP_LW, OP_SW:   state_nxt = S_MEM_ADDR;
          OP_ORI, OP_ADDI: state_nxt = S_IMM_EXEC;
          OP_BEQ:         state_nxt = S_BRANCH;
          OP_J:           state_nxt = S_JUMP;
          default: begin state_nxt = S_ERROR; err_nxt = E_OP; end
        endcase
      end
      S_EXEC:     state_nxt = S_R_WB;
      S_MEM_ADDR: state_nxt = (op == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_IMM_EXEC: state_nxt = S_IMM_WB;
      S_R_WB, S_MEM_WB, S_IMM_WB, S_BRANCH, S_JUMP: state_nxt = S_FETCH;
      S_FETCH, S_MEM_READ, S_MEM_WRITE: begin
        // A ready on the last permitted cycle completes the transfer rather than timing out.
        if (mem_ready)
          state_nxt = (state_q == S_FETCH)    ? S_DECODE :
                      (state_q == S_MEM_READ) ? S_MEM_WB : S_FETCH;
        else if (timeout) begin
          state_nxt = S_ERROR;
          err_nxt   = E_TMO;
        end
      end
      S_ERROR:  state_nxt = S_ERROR;
      default:  state_nxt = S_RST;
    endcase
  end

  // Any state change clears the counter, which covers every entry into a wait state.
  always_comb begin
    wait_nxt = wait_cnt;
    if (state_nxt != state_q)      wait_nxt = '0;
    else if (waiting && !mem_ready) wait_nxt = wait_cnt + 1'b1;
  end

  always_comb begin
    iord = 1'b0; mem_read = 1'b0; mem_write = 1'b0; ir_write = 1'b0; pc_write = 1'b0;
    pc_source = 2'b00; alu_src_a = 1'b0; alu_src_b = 2'b00; extop = 1'b0; alu_ctr = 3'b000;
    reg_dst = 1'b0; mem_to_reg = 1'b0; reg_write = 1'b0; instr_done = 1'b0; error = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read = 1'b1; alu_src_b = 2'b01; alu_ctr = 3'b010;
        ir_write = mem_ready; pc_write = mem_ready;
      end
      S_DECODE:   begin alu_src_b = 2'b11; extop = 1'b1; alu_ctr = 3'b010; end
      S_EXEC:     begin alu_src_a = 1'b1; alu_ctr = r_alu; end
      S_R_WB: begin
        alu_src_a = 1'b1; alu_ctr = r_alu;
        reg_dst = 1'b1; reg_write = 1'b1; instr_done = 1'b1;
      end
      S_MEM_ADDR: begin alu_src_a = 1'b1; alu_src_b = 2'b10; extop = 1'b1; alu_ctr = 3'b010; end
      S_MEM_READ: begin mem_read = 1'b1; iord = 1'b1; end
      S_MEM_WB:   begin mem_to_reg = 1'b1; reg_write = 1'b1; instr_done = 1'b1; end
      S_MEM_WRITE: begin mem_write = 1'b1; iord = 1'b1; instr_done = mem_ready; end
      S_IMM_EXEC, S_IMM_WB: begin
        alu_src_a = 1'b1; alu_src_b = 2'b10;
        extop     = (op != OP_ORI);
        alu_ctr   = (op == OP_ORI) ? 3'b001 : 3'b010;
        reg_write  = (state_q == S_IMM_WB);
        instr_done = (state_q == S_IMM_WB);
      end
      S_BRANCH: begin
        alu_src_a = 1'b1; alu_ctr = 3'b110; pc_source = 2'b01;
        pc_write = zero; instr_done = 1'b1;
      end
      S_JUMP:  begin pc_source = 2'b10; pc_write = 1'b1; instr_done = 1'b1; end
      S_ERROR: error = 1'b1;
      default: ;
    endcase
  end

  assign state    = state_q;
  assign err_code = err_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: expected per-cycle control vectors are queued
// as each cycle is driven and popped against the DUT at the following falling edge.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] op = '0, funct = '0;
  logic       zero = 1'b0, mem_ready = 1'b0;
  logic       iord, mem_read, mem_write, ir_write, pc_write, alu_src_a, extop;
  logic       reg_dst, mem_to_reg, reg_write, instr_done, error;
  logic [1:0] pc_source, alu_src_b, err_code;
  logic [2:0] alu_ctr;
  logic [3:0] state;

  int checks = 0;
  int failures = 0;
  int done_pulses;
  logic [24:0] sb[$];

  localparam logic [3:0] RST = 0, FETCH = 1, DECODE = 2, EXEC = 3, R_WB = 4, MEM_ADDR = 5,
    MEM_READ = 6, MEM_WB = 7, MEM_WRITE = 8, IMM_EXEC = 9, IMM_WB = 10, BRANCH = 11,
    JUMP = 12, ERR = 13;

  multicycle_control #(.WAIT_W(4), .MAX_WAIT(15)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .pc_write(pc_write), .pc_source(pc_source), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .extop(extop), .alu_ctr(alu_ctr), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .instr_done(instr_done), .error(error), .err_code(err_code),
    .state(state)
  );

  always #5 clk = ~clk;

  wire [24:0] act = {iord, mem_read, mem_write, ir_write, pc_write, pc_source, alu_src_a,
                     alu_src_b, extop, alu_ctr, reg_dst, mem_to_reg, reg_write, instr_done,
                     error, err_code, state};

  function automatic logic [2:0] r_alu(input logic [5:0] f);
    if (f == 6'b100000) return 3'b010;
    if (f == 6'b100010) return 3'b110;
    if (f == 6'b100100) return 3'b000;
    if (f == 6'b100101) return 3'b001;
    return 3'b111;
  endfunction

  // Spec table of per-state control values; fields in the same order as act.
  function automatic logic [24:0] model(input logic [3:0] st, input logic mr, input logic z,
                                        input logic [1:0] ec);
    logic io, mrd, mwr, irw, pcw, sa, ex, rd, m2r, rw, dn, er;
    logic [1:0] ps, sb_, code;
    logic [2:0] ac;
    {io, mrd, mwr, irw, pcw, sa, ex, rd, m2r, rw, dn, er} = '0;
    ps = 2'b00; sb_ = 2'b00; ac = 3'b000; code = 2'b00;
    case (st)
      FETCH:     begin mrd = 1; sb_ = 2'b01; ac = 3'b010; irw = mr; pcw = mr; end
      DECODE:    begin sb_ = 2'b11; ex = 1; ac = 3'b010; end
      EXEC:      begin sa = 1; ac = r_alu(funct); end
      R_WB:      begin sa = 1; ac = r_alu(funct); rd = 1; rw = 1; dn = 1; end
      MEM_ADDR:  begin sa = 1; sb_ = 2'b10; ex = 1; ac = 3'b010; end
      MEM_READ:  begin mrd = 1; io = 1; end
      MEM_WB:    begin m2r = 1; rw = 1; dn = 1; end
      MEM_WRITE: begin mwr = 1; io = 1; dn = mr; end
      IMM_EXEC, IMM_WB: begin
        sa = 1; sb_ = 2'b10;
        if (op == 6'b001101) begin ex = 0; ac = 3'b001; end else begin ex = 1; ac = 3'b010; end
        if (st == IMM_WB) begin rw = 1; dn = 1; end
      end
      BRANCH:    begin sa = 1; ac = 3'b110; ps = 2'b01; pcw = z; dn = 1; end
      JUMP:      begin ps = 2'b10; pcw = 1; dn = 1; end
      ERR:       begin er = 1; code = ec; end
      default: ;
    endcase
    return {io, mrd, mwr, irw, pcw, ps, sa, sb_, ex, ac, rd, m2r, rw, dn, er, code, st};
  endfunction

  // Called at posedge+1: drive this cycle's inputs, queue the expectation, compare at negedge.
  task automatic step(input logic [3:0] st, input logic mr, input logic z,
                      input logic [1:0] ec, input string nm);
    logic [24:0] e;
    mem_ready = mr;
    zero = z;
    sb.push_back(model(st, mr, z, ec));
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (act !== e) begin
      failures++;
      $display("FAIL %s: got %h (state %0d) expected %h (state %0d)", nm, act, state, e, e[3:0]);
    end
    if (instr_done === 1'b1) done_pulses++;
    @(posedge clk);
    #1;
  endtask

  // Ends at posedge+1 with the DUT in its first FETCH cycle.
  task automatic do_reset();
    rst_n = 0;
    #1;
    checks++;
    if (act !== '0) begin failures++; $display("FAIL reset_outputs: got %h expected 0", act); end
    @(negedge clk);
    rst_n = 1;
    #1;
    checks++;
    if (state !== RST) begin failures++; $display("FAIL reset_state: got %0d expected %0d", state, RST); end
    @(posedge clk);
    #1;
    done_pulses = 0;
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    do_reset();
  endtask

  task automatic test_lw();
    op = 6'b100011; funct = '0;
    do_reset();
    step(FETCH, 1, 0, 0, "lw_fetch");
    step(DECODE, 1, 0, 0, "lw_decode");
    step(MEM_ADDR, 1, 0, 0, "lw_addr");
    step(MEM_READ, 1, 0, 0, "lw_read");
    step(MEM_WB, 1, 0, 0, "lw_wb");
    checks++;
    if (done_pulses !== 1) begin failures++; $display("FAIL lw_done_pulses: got %0d expected 1", done_pulses); end
    step(FETCH, 0, 0, 0, "lw_next_fetch");
  endtask

  task automatic test_rtype();
    logic [5:0] fs [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    logic [2:0] ac [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
    op = 6'b000000;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      funct = fs[i];
      step(FETCH, 1, 0, 0, "r_fetch");
      step(DECODE, 0, 0, 0, "r_decode");
      checks++;
      if (alu_ctr !== ac[i]) begin
        failures++;
        $display("FAIL r_alu_ctr[%0d]: got %b expected %b", i, alu_ctr, ac[i]);
      end
      step(EXEC, 1, 0, 0, "r_exec");
      step(R_WB, 0, 0, 0, "r_wb");
    end
  endtask

  task automatic test_imm();
    logic [5:0] ops [2] = '{6'b001101, 6'b001000};
    do_reset();
    for (int i = 0; i < 2; i++) begin
      op = ops[i];
      step(FETCH, 1, 0, 0, "imm_fetch");
      step(DECODE, 0, 0, 0, "imm_decode");
      step(IMM_EXEC, 0, 0, 0, "imm_exec");
      step(IMM_WB, 0, 0, 0, "imm_wb");
    end
  endtask

  task automatic test_branch_jump();
    do_reset();
    op = 6'b000100;
    for (int z = 1; z >= 0; z--) begin
      step(FETCH, 1, 0, 0, "beq_fetch");
      step(DECODE, 0, 0, 0, "beq_decode");
      step(BRANCH, 0, logic'(z), 0, "beq_branch");
    end
    op = 6'b000010;
    step(FETCH, 1, 0, 0, "j_fetch");
    step(DECODE, 0, 0, 0, "j_decode");
    step(JUMP, 1, 0, 0, "j_jump");
    step(FETCH, 0, 0, 0, "j_next_fetch");
  endtask

  task automatic test_wait_states();
    op = 6'b101011;
    do_reset();
    step(FETCH, 1, 0, 0, "sw_fetch");
    step(DECODE, 0, 0, 0, "sw_decode");
    step(MEM_ADDR, 1, 0, 0, "sw_addr");
    for (int i = 0; i < 3; i++) step(MEM_WRITE, 0, 0, 0, "sw_wait");
    step(MEM_WRITE, 1, 0, 0, "sw_done");
    checks++;
    if (done_pulses !== 1) begin failures++; $display("FAIL sw_done_pulses: got %0d expected 1", done_pulses); end
    step(FETCH, 1, 0, 0, "sw_next_fetch");
  endtask

  task automatic test_timeout();
    op = 6'b100011;
    do_reset();
    for (int i = 0; i < 15; i++) step(FETCH, 0, 0, 0, "tmo_fetch");
    step(ERR, 1, 0, 2'b11, "tmo_error");
    step(ERR, 1, 0, 2'b11, "tmo_sticky");
    do_reset();
    for (int i = 0; i < 14; i++) step(FETCH, 0, 0, 0, "edge_fetch");
    step(FETCH, 1, 0, 0, "edge_ready");
    step(DECODE, 0, 0, 0, "edge_decode");
  endtask

  task automatic test_illegal();
    logic [5:0] ops [2] = '{6'b111111, 6'b000000};
    logic [1:0] ecs [2] = '{2'b01, 2'b10};
    funct = 6'b000011;
    for (int i = 0; i < 2; i++) begin
      op = ops[i];
      do_reset();
      step(FETCH, 1, 0, 0, "ill_fetch");
      step(DECODE, 1, 1, 0, "ill_decode");
      for (int k = 0; k < 3; k++) step(ERR, 1, 1, ecs[i], "ill_error");
    end
    op = 6'b000010;
    do_reset();
    step(FETCH, 1, 0, 0, "post_fetch");
    step(DECODE, 0, 0, 0, "post_decode");
  endtask

  initial begin
    test_reset();
    test_lw();
    test_rtype();
    test_imm();
    test_branch_jump();
    test_wait_states();
    test_timeout();
    test_illegal();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle successor to the single-cycle main/ALU controller. A Moore-style FSM, with two qualified Mealy strobes, sequences the shared-ALU multi-cycle MIPS datapath: instruction fetch, decode, execute, memory and write-back. Memory accesses wait on a ready handshake and are guarded by a parametrised watchdog. Illegal opcodes, illegal functs and memory timeouts drive a sticky error state. The block sits between the instruction register and every datapath mux/enable.

## Interface
Parameters:
- WAIT_W, 4: width of the memory-wait counter.
- MAX_WAIT, 15: number of consecutive not-ready cycles that is a timeout; must be < 2**WAIT_W.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- op  in  6  IR[31:26].
- funct  in  6  IR[5:0].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completed the current read/write this cycle.
- iord  out  1  memory address: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  IR load enable.
- pc_write  out  1  PC load enable.
- pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- alu_src_a  out  1  0 = PC, 1 = reg A.
- alu_src_b  out  2  00 = reg B, 01 = const 4, 10 = ext imm, 11 = ext imm<<2.
- extop  out  1  1 = sign-extend, 0 = zero-extend.
- alu_ctr  out  3  000 and, 001 or, 010 add, 110 sub, 111 slt.
- reg_dst  out  1  1 = rd, 0 = rt.
- mem_to_reg  out  1  write-back source is MDR.
- reg_write  out  1  register file write enable.
- instr_done  out  1  pulses on the final cycle of each instruction.
- error  out  1  sticky; high in ERROR.
- err_code  out  2  00 none, 01 illegal op, 10 illegal funct, 11 memory timeout.
- state  out  4  current state, for debug.

## Operation
- States: RST, FETCH, DECODE, EXEC, R_WB, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, IMM_EXEC, IMM_WB, BRANCH, JUMP, ERROR.
- Every output not listed for a state is 0.
- RST: all outputs 0. Always moves to FETCH.
- FETCH:
  - Outputs: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_ctr=add.
  - When mem_ready=1: ir_write=1 and pc_write=1 (Mealy), then go to DECODE.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=11, extop=1, alu_ctr=add (precomputes the branch target).
  - Next state by op: 000000 -> EXEC; 100011 or 101011 -> MEM_ADDR; 001101 (ORI) or 001000 (ADDI) -> IMM_EXEC; 000100 -> BRANCH; 000010 -> JUMP; any other op -> ERROR with code 01.
  - R-type with funct not in {100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt} -> ERROR with code 10.
- EXEC: alu_src_a=1, alu_src_b=00, alu_ctr decoded from funct. Next R_WB.
- R_WB: EXEC ALU selects held, reg_dst=1, reg_write=1, instr_done=1. Next FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, extop=1, add. Next MEM_READ for LW, MEM_WRITE for SW.
- MEM_READ: mem_read=1, iord=1. On mem_ready go to MEM_WB.
- MEM_WB: mem_to_reg=1, reg_dst=0, reg_write=1, instr_done=1. Next FETCH.
- MEM_WRITE: mem_write=1, iord=1. On mem_ready, instr_done=1 (Mealy) and go to FETCH.
- IMM_EXEC: alu_src_a=1, alu_src_b=10.
  - ORI: extop=0, alu_ctr=or.
  - ADDI: extop=1, alu_ctr=add.
  - Next IMM_WB.
- IMM_WB: IMM_EXEC selects held, reg_dst=0, reg_write=1, instr_done=1. Next FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_ctr=sub, pc_source=01, pc_write=zero, instr_done=1. Next FETCH.
- JUMP: pc_source=10, pc_write=1, instr_done=1. Next FETCH.
- ERROR:
  - All enables 0; error=1; err_code holds the first cause.
  - Exits only on reset.
- Watchdog:
  - wait_cnt clears to 0 on entry to FETCH, MEM_READ and MEM_WRITE.
  - In those states it increments each cycle that mem_ready=0.
  - If mem_ready=0 while wait_cnt==MAX_WAIT-1, the next state is ERROR with code 11.
  - mem_ready=1 on that same cycle wins: the transfer completes and there is no timeout.

## Timing
- Reset is asynchronous: state=RST, wait_cnt=0, err_code=00 immediately. All outputs are therefore 0 during reset.
- The first FETCH is the cycle after the first rising edge with rst_n=1.
- Cycle counts with zero wait states (mem_ready=1 on the first cycle):
  - R-type, ORI, ADDI, SW: 4 cycles.
  - LW: 5 cycles.
  - BEQ, J: 3 cycles.
- Each wait cycle adds 1 to the instruction.
- Outputs are decoded from the state register. Only ir_write, pc_write (in FETCH) and instr_done (in MEM_WRITE) also depend on mem_ready, and pc_write in BRANCH depends on zero.
- mem_read/mem_write stay asserted, with a stable iord, until the cycle mem_ready is seen.
- A mem_ready seen in any state other than FETCH, MEM_READ or MEM_WRITE is ignored.
- Reset asserted mid-instruction aborts it immediately; there are no partial writes after reset is asserted.

## Test plan
- Reset then LW: op=100011, mem_ready always 1 -> states RST, FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB. reg_write=1 and mem_to_reg=1 only in MEM_WB; instr_done is a single pulse.
- R-type sweep: funct 100000/100010/100100/100101/101010 -> alu_ctr 010/110/000/001/111 in EXEC. reg_dst=1 and reg_write=1 in R_WB; 4 cycles each.
- BEQ: zero=1 -> pc_write=1 with pc_source=01 in BRANCH. zero=0 -> pc_write=0. Both cases take 3 cycles.
- Wait states: SW with mem_ready low for 3 cycles in MEM_WRITE -> mem_write and iord held for 4 cycles; the instruction totals 7 cycles.
- Timeout: MAX_WAIT=15 with mem_ready stuck at 0 in FETCH -> ERROR after 15 FETCH cycles, err_code=11. With mem_ready=1 on the 15th cycle -> DECODE instead.
- Illegal cases:
  - op=111111 -> ERROR with err_code=01 after DECODE.
  - R-type funct=000011 -> err_code=10.
  - In both: all enables stay 0 until rst_n pulses low, then RST, then FETCH.
